// File: rtl/rx_timer_pkg.sv
// rtl/rx_timer_pkg.sv - shared types and constants for the receiver bit timer
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } timer_state_t;

  localparam logic MODE_END       = 1'b0;
  localparam logic MODE_MID       = 1'b1;
  localparam int   MIN_BIT_PERIOD = 2;

endpackage

// File: rtl/rx_period_cnt.sv
// rtl/rx_period_cnt.sv - bit-period counter that runs 1..limit and wraps back to 1
module rx_period_cnt #(
  parameter int CNT_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrap
);

  assign wrap = (count == limit);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_WIDTH'(1);
    end else if (en) begin
      count <= wrap ? CNT_WIDTH'(1) : count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - packet bit timer issuing per-bit sample strobes and a done pulse
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 14,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable_timer,
  input  logic [CNT_WIDTH-1:0] bit_period,
  input  logic [LEN_WIDTH-1:0] packet_bits,
  input  logic                 sample_mode,
  output logic                 shift_enable,
  output logic                 packet_done,
  output logic [LEN_WIDTH-1:0] bit_count,
  output logic                 busy,
  output logic                 cfg_error
);

  timer_state_t         state, state_d;
  logic [CNT_WIDTH-1:0] bp_q;
  logic [LEN_WIDTH-1:0] pb_q;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] clk_cnt;
  logic                 wrap;
  logic [LEN_WIDTH-1:0] bit_count_d;
  logic                 packet_done_d;
  logic                 cnt_clear, cnt_load, cnt_en;
  logic                 cfg_bad, start, hit, strobe, last_strobe;

  rx_period_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_period_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .load  (cnt_load),
    .en    (cnt_en),
    .limit (bp_q),
    .count (clk_cnt),
    .wrap  (wrap)
  );

  always_comb begin
    cfg_bad = (bit_period < CNT_WIDTH'(MIN_BIT_PERIOD)) || (packet_bits == '0);
    start   = (state == IDLE) && enable_timer;

    // End-of-bit sampling coincides with the counter wrap; mid-bit uses the floored half period.
    hit = 1'b0;
    case (mode_q)
      MODE_END: hit = wrap;
      MODE_MID: hit = (clk_cnt == (bp_q >> 1));
      default:  hit = 1'b0;
    endcase
    strobe      = (state == RUN) && hit;
    last_strobe = strobe && (bit_count == pb_q - LEN_WIDTH'(1));

    state_d       = state;
    bit_count_d   = bit_count;
    packet_done_d = 1'b0;
    cnt_clear     = 1'b1;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;

    case (state)
      IDLE: begin
        if (enable_timer) begin
          state_d     = cfg_bad ? ERR : RUN;
          bit_count_d = '0;
          cnt_clear   = cfg_bad;
          cnt_load    = !cfg_bad;
        end
      end
      RUN: begin
        if (!enable_timer) begin
          state_d     = IDLE;
          bit_count_d = '0;
        end else if (last_strobe) begin
          state_d       = DONE;
          bit_count_d   = pb_q;
          packet_done_d = 1'b1;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
          if (strobe) bit_count_d = bit_count + LEN_WIDTH'(1);
        end
      end
      DONE: begin
        if (!enable_timer) begin
          state_d     = IDLE;
          bit_count_d = '0;
        end
      end
      ERR: begin
        if (!enable_timer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      bit_count   <= '0;
      packet_done <= 1'b0;
      bp_q        <= '0;
      pb_q        <= '0;
      mode_q      <= 1'b0;
    end else begin
      state       <= state_d;
      bit_count   <= bit_count_d;
      packet_done <= packet_done_d;
      if (start) begin
        bp_q   <= bit_period;
        pb_q   <= packet_bits;
        mode_q <= sample_mode;
      end
    end
  end

  assign shift_enable = strobe;
  assign busy         = (state == RUN);
  assign cfg_error    = (state == ERR);

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
Parametrised, runtime-configurable bit timer for the serial receiver datapath. It times one packet of bit periods after start-bit detection and issues a per-bit sample strobe (shift_enable) to the shift register. It raises a one-cycle packet_done after the last bit. Generalises the fixed divide-by-10, 9-bit timer with the following:
- programmable bit period and packet length;
- selectable end-of-bit or mid-bit sampling;
- configuration checking;
- an explicit done/idle handshake.

Parameters:
CNT_WIDTH, 14, width of bit-period counter and bit_period input (max period 2^CNT_WIDTH-1 clocks)
LEN_WIDTH, 4, width of packet_bits and bit_count (max 2^LEN_WIDTH-1 bits per packet)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
enable_timer  input  1  level; 1 = run packet, 0 = synchronous abort/clear
bit_period  input  CNT_WIDTH  clocks per bit; latched at start
packet_bits  input  LEN_WIDTH  bit periods per packet (e.g. 9 = 8 data + stop); latched at start
sample_mode  input  1  0 = strobe at end of bit period, 1 = strobe at mid-bit; latched at start
shift_enable  output  1  one-cycle sample strobe per bit
packet_done  output  1  one-cycle pulse after the final strobe
bit_count  output  LEN_WIDTH  strobes issued so far in the current packet
busy  output  1  1 while in RUN
cfg_error  output  1  1 while in ERR

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous, active-low.
- Reset values: state=IDLE, clk_cnt=0, bit_count=0, latched config=0. All outputs are 0.
- States: IDLE, RUN, DONE, ERR.
- IDLE:
  - On a clk edge with enable_timer=1, latch bit_period, packet_bits and sample_mode.
  - If latched bit_period<2 or packet_bits==0, go to ERR.
  - Otherwise go to RUN with clk_cnt=1 and bit_count=0.
- RUN:
  - clk_cnt counts 1..bit_period and wraps to 1 on the cycle after clk_cnt==bit_period.
  - Strobe point: sp = bit_period (mode 0), or sp = bit_period>>1, floored (mode 1).
  - shift_enable = (state==RUN && clk_cnt==sp). It is decoded from registers only, so it is glitch-free.
  - bit_count increments on the edge that ends a strobe cycle.
  - When a strobe occurs with bit_count==packet_bits-1, the next state is DONE, bit_count becomes packet_bits, and packet_done is registered high for exactly one cycle.
- DONE:
  - bit_count is held, busy=0, and there are no strobes.
  - On enable_timer=0, go to IDLE and clear bit_count. While enable_timer stays 1, remain in DONE; the block does not auto-restart.
- ERR:
  - cfg_error=1 and there are no strobes.
  - On enable_timer=0, go to IDLE.
- Abort: enable_timer=0 in RUN means next state IDLE, clk_cnt=0, bit_count=0. packet_done is not asserted, even if the final strobe coincides.
- Latency (mode 0):
  - The first strobe occurs bit_period cycles after the start edge.
  - packet_done occurs packet_bits*bit_period+1 cycles after the start edge.
- Latency (mode 1):
  - The first strobe occurs at sp.
  - packet_done occurs (packet_bits-1)*bit_period+sp+1 cycles after the start edge.
  - The remaining half of the final bit is not timed.
- Config inputs changing during RUN/DONE/ERR have no effect until the next IDLE start.
- Asynchronous reset mid-packet returns all state to reset values immediately. No pulse is emitted.
- Width: the clk_cnt compare is full CNT_WIDTH. Counter and bit_count arithmetic is unsigned with no overflow possible given the config check.

Decomposition:
- Package rx_timer_pkg: state enum typedef (IDLE, RUN, DONE, ERR), MODE_END=1'b0 and MODE_MID=1'b1 constants, MIN_BIT_PERIOD=2.
- One natural sub-module: rx_period_cnt, the CNT_WIDTH wrap-at-limit counter with clear and enable. It outputs clk_cnt and a wrap flag.
- The FSM and bit counter stay in rx_bit_timer.

Test Plan:
- Mode 0, bp=10, pb=9, enable held -> shift_enable high at cycles 10,20,...,90 after start; packet_done at cycle 91; bit_count=9 held; busy=0.
- Mode 1, bp=16, pb=10 -> strobes at cycles 8,24,...,152; packet_done at 153. Also bp=5 -> sp=2.
- Abort: mode 0, bp=10, pb=9, drop enable at cycle 35 -> next cycle busy=0, bit_count=0, no further strobes, no packet_done. Re-enable -> fresh packet timing.
- Config error: bp=1 or pb=0 -> cfg_error=1, busy=0, zero strobes. Drop enable -> cfg_error=0. Next valid start runs normally.
- Mid-packet changes: alter bit_period/packet_bits/sample_mode at cycle 25 -> timing unchanged from latched values. Assert n_rst=0 mid-packet -> all outputs 0 immediately.
- Back-to-back: hold enable after done -> stays DONE, no strobes. Toggle enable 0 then 1 -> second packet identical to the first.
